// File: rtl/cv32e40p_fpu_lat_pkg.sv
// rtl/cv32e40p_fpu_lat_pkg.sv - shared types and helpers for the FPU latency-equalisation pipe
// Contents: default result/fflags/tag widths, the pipe entry struct, max_lat and highest_set.
package cv32e40p_fpu_lat_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned TAG_W  = 5;

  // Widest stage-valid vector highest_set() can scan; bounds MAX_LAT.
  localparam int unsigned VEC_W  = 32;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [FLAG_W-1:0] flags;
    logic [TAG_W-1:0]  tag;
  } lat_entry_t;

  // Running maximum, folded over the group latency table at elaboration.
  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Highest occupied stage index >= 2 (bit k = stage k), or 0 when none.
  // Stage 1 is ignored: it always drains or freezes the whole pipe.
  function automatic int unsigned highest_set(input logic [VEC_W-1:0] vld);
    int unsigned k;
    k = 0;
    for (int unsigned i = 2; i < VEC_W; i++) begin
      if (vld[i]) k = i;
    end
    return k;
  endfunction

endpackage

// File: rtl/cv32e40p_fpu_lat_stage.sv
// rtl/cv32e40p_fpu_lat_stage.sv - one valid+entry register of the FPU latency pipe
// Ports: clr_i (drop entry), hold_i (freeze), load_i/load_ent_i (new result),
//        shift_vld_i/shift_ent_i (entry from the stage above), vld_o/ent_o (state).
// Control priority: clear > hold > load > shift.
module cv32e40p_fpu_lat_stage #(
  parameter int unsigned W = 42
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         hold_i,
  input  logic         load_i,
  input  logic [W-1:0] load_ent_i,
  input  logic         shift_vld_i,
  input  logic [W-1:0] shift_ent_i,
  output logic         vld_o,
  output logic [W-1:0] ent_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_o <= 1'b0;
      ent_o <= '0;
    end else if (clr_i) begin
      // Payload is left as-is; the output mux masks it while invalid.
      vld_o <= 1'b0;
    end else if (hold_i) begin
      vld_o <= vld_o;
    end else if (load_i) begin
      vld_o <= 1'b1;
      ent_o <= load_ent_i;
    end else begin
      vld_o <= shift_vld_i;
      ent_o <= shift_ent_i;
    end
  end

endmodule

// File: rtl/cv32e40p_fpu_lat_pipe.sv
// rtl/cv32e40p_fpu_lat_pipe.sv - in-order latency-equalisation pipe between FPU and FP writeback
// Ports: flush_i kills in-flight results; in_* is the FPU result with group index in_grp_i;
//        out_* is the result towards writeback (valid/ready); busy_o flags any occupied stage.
// A result of group g is written to stage GRP_LAT[g] and shifts down one stage per unfrozen
// cycle; stage 1 drives the output. Latency-0 groups bypass combinationally when empty.
module cv32e40p_fpu_lat_pipe
  import cv32e40p_fpu_lat_pkg::max_lat;
  import cv32e40p_fpu_lat_pkg::highest_set;
  import cv32e40p_fpu_lat_pkg::VEC_W;
#(
  parameter  int unsigned NUM_GRP          = 2,
  parameter  int unsigned MAX_LAT          = 4,
  parameter  int unsigned GRP_LAT [NUM_GRP] = '{0, 0},
  parameter  int unsigned DATA_W           = 32,
  parameter  int unsigned FLAG_W           = 5,
  parameter  int unsigned TAG_W            = 5,
  localparam int unsigned GRP_W            = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [GRP_W-1:0]  in_grp_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [FLAG_W-1:0] in_flags_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [FLAG_W-1:0] out_flags_o,
  output logic [TAG_W-1:0]  out_tag_o,
  output logic              busy_o
);

  localparam int unsigned ENT_W = DATA_W + FLAG_W + TAG_W;

  if (NUM_GRP < 1) begin : g_err_grp
    $fatal(1, "cv32e40p_fpu_lat_pipe: NUM_GRP must be >= 1");
  end
  if (MAX_LAT < 1 || MAX_LAT >= VEC_W) begin : g_err_lat
    $fatal(1, "cv32e40p_fpu_lat_pipe: MAX_LAT out of range");
  end
  for (genvar g = 0; g < NUM_GRP; g++) begin : g_chk
    if (max_lat(GRP_LAT[g], MAX_LAT) != MAX_LAT) begin : g_err
      $fatal(1, "cv32e40p_fpu_lat_pipe: GRP_LAT element exceeds MAX_LAT");
    end
  end

  logic [MAX_LAT:1] vld;
  logic [ENT_W-1:0] ent [1:MAX_LAT];
  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] out_ent;
  int unsigned      lat_sel;
  int unsigned      kmax;
  logic             any_vld;
  logic             bypass;
  logic             freeze;
  logic             accept;

  always_comb begin
    lat_sel = 0;
    for (int g = 0; g < NUM_GRP; g++) begin
      if (in_grp_i == GRP_W'(g)) lat_sel = GRP_LAT[g];
    end
  end

  assign in_ent  = {in_data_i, in_flags_i, in_tag_i};
  assign any_vld = |vld;
  assign busy_o  = any_vld;
  assign kmax    = highest_set(VEC_W'({vld, 1'b0}));
  assign bypass  = (lat_sel == 0) && !any_vld && !flush_i;
  assign freeze  = vld[1] && !out_ready_i;

  // Writing at stage L is safe only if nothing sits above L after the shift:
  // that keeps slots collision-free and retirement in issue order.
  always_comb begin
    in_ready_o = 1'b0;
    if (rst_n && !flush_i) begin
      if (lat_sel == 0) in_ready_o = bypass && out_ready_i;
      else              in_ready_o = !freeze && (lat_sel >= kmax);
    end
  end

  assign accept = in_valid_i && in_ready_o && (lat_sel != 0);

  always_comb begin
    out_valid_o = 1'b0;
    out_ent     = '0;
    if (rst_n && !flush_i) begin
      if (vld[1]) begin
        out_valid_o = 1'b1;
        out_ent     = ent[1];
      end else if (bypass && in_valid_i) begin
        out_valid_o = 1'b1;
        out_ent     = in_ent;
      end
    end
  end

  assign {out_data_o, out_flags_o, out_tag_o} = out_ent;

  for (genvar k = 1; k <= MAX_LAT; k++) begin : g_stage
    localparam int unsigned KU = k;
    logic             sh_vld;
    logic [ENT_W-1:0] sh_ent;

    if (k < MAX_LAT) begin : g_mid
      assign sh_vld = vld[k+1];
      assign sh_ent = ent[k+1];
    end else begin : g_top
      assign sh_vld = 1'b0;
      assign sh_ent = '0;
    end

    cv32e40p_fpu_lat_stage #(.W(ENT_W)) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (flush_i),
      .hold_i      (freeze),
      .load_i      (accept && (lat_sel == KU)),
      .load_ent_i  (in_ent),
      .shift_vld_i (sh_vld),
      .shift_ent_i (sh_ent),
      .vld_o       (vld[k]),
      .ent_o       (ent[k])
    );
  end

endmodule

// File: tb/tb_cv32e40p_fpu_lat_pipe.sv
// tb/tb_cv32e40p_fpu_lat_pipe.sv - bench for cv32e40p_fpu_lat_pipe, two configurations in lockstep
module tb_cv32e40p_fpu_lat_pipe;
  import cv32e40p_fpu_lat_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_grp = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_flags = '0;
  logic [4:0]  in_tag = '0;
  logic        out_ready = 1'b1;

  logic        a_in_ready, a_out_valid, a_busy;
  logic [31:0] a_out_data;
  logic [4:0]  a_out_flags, a_out_tag;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [31:0] b_out_data;
  logic [4:0]  b_out_flags, b_out_tag;

  always #5 clk = ~clk;

  cv32e40p_fpu_lat_pipe #(
    .NUM_GRP(2), .MAX_LAT(4), .GRP_LAT('{1, 3}), .DATA_W(32), .FLAG_W(5), .TAG_W(5)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_grp_i(in_grp),
    .in_data_i(in_data), .in_flags_i(in_flags), .in_tag_i(in_tag),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready),
    .out_data_o(a_out_data), .out_flags_o(a_out_flags), .out_tag_o(a_out_tag),
    .busy_o(a_busy)
  );

  cv32e40p_fpu_lat_pipe #(
    .NUM_GRP(2), .MAX_LAT(4), .GRP_LAT('{0, 2}), .DATA_W(32), .FLAG_W(5), .TAG_W(5)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_grp_i(in_grp),
    .in_data_i(in_data), .in_flags_i(in_flags), .in_tag_i(in_tag),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready),
    .out_data_o(b_out_data), .out_flags_o(b_out_flags), .out_tag_o(b_out_tag),
    .busy_o(b_busy)
  );

  // Reference: per-DUT list of in-flight results in issue order, each with the
  // number of unfrozen cycles left before it is shown on the output.
  typedef struct {
    lat_entry_t e;
    int         rem;
    int         d;
  } ment_t;

  ment_t mq[$];
  int    checks = 0;
  int    failures = 0;
  logic  s_valid [2];
  logic  s_ready [2];
  logic  s_busy  [2];
  logic [4:0] s_tag [2];

  function automatic int lat_of(input int d, input logic g);
    if (d == 0) return g ? 3 : 1;
    return g ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_eval(input int d, output logic ev, output lat_entry_t eo,
                            output logic er, output logic eb);
    int head, maxrem, cnt, lat;
    head = -1; maxrem = 0; cnt = 0; ev = 1'b0; eo = '0;
    foreach (mq[i]) begin
      if (mq[i].d == d) begin
        if (head < 0) head = i;
        if (mq[i].rem > maxrem) maxrem = mq[i].rem;
        cnt++;
      end
    end
    lat = lat_of(d, in_grp);
    eb = (cnt != 0);
    if (!flush) begin
      if (head >= 0 && mq[head].rem == 0) begin
        ev = 1'b1;
        eo = mq[head].e;
      end else if (cnt == 0 && lat == 0 && in_valid) begin
        ev = 1'b1;
        eo = '{data: in_data, flags: in_flags, tag: in_tag};
      end
    end
    if (flush)         er = 1'b0;
    else if (lat == 0) er = (cnt == 0) && out_ready;
    else               er = !(head >= 0 && mq[head].rem == 0 && !out_ready) && (lat - 1 >= maxrem);
  endtask

  task automatic model_step(input int d, input logic er);
    int head, lat;
    logic present;
    lat = lat_of(d, in_grp);
    if (flush) begin
      for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].d == d) mq.delete(i);
      return;
    end
    head = -1;
    foreach (mq[i]) if (mq[i].d == d && head < 0) head = i;
    present = (head >= 0) && (mq[head].rem == 0);
    if (present && !out_ready) return;
    if (present) mq.delete(head);
    foreach (mq[i]) if (mq[i].d == d && mq[i].rem > 0) mq[i].rem = mq[i].rem - 1;
    if (in_valid && er && lat >= 1)
      mq.push_back('{e: '{data: in_data, flags: in_flags, tag: in_tag}, rem: lat - 1, d: d});
  endtask

  // One clock cycle: drive inputs, check both DUTs against the model mid-cycle, advance the model.
  task automatic cyc(input logic v, input logic g, input logic [4:0] t, input logic ordy, input logic fl);
    logic       ev, er, eb, ov, ordy_o, ob;
    logic       er_d [2];
    lat_entry_t eo, oe;
    in_valid = v; in_grp = g; in_tag = t; out_ready = ordy; flush = fl;
    in_data = $urandom; in_flags = 5'($urandom);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      model_eval(d, ev, eo, er, eb);
      ov     = (d == 0) ? a_out_valid : b_out_valid;
      ordy_o = (d == 0) ? a_in_ready  : b_in_ready;
      ob     = (d == 0) ? a_busy      : b_busy;
      oe     = (d == 0) ? '{data: a_out_data, flags: a_out_flags, tag: a_out_tag}
                        : '{data: b_out_data, flags: b_out_flags, tag: b_out_tag};
      chk($sformatf("d%0d_out_valid", d), 64'(ov), 64'(ev));
      chk($sformatf("d%0d_in_ready", d), 64'(ordy_o), 64'(er));
      chk($sformatf("d%0d_busy", d), 64'(ob), 64'(eb));
      chk($sformatf("d%0d_out_entry", d), 64'(oe), 64'(eo));
      s_valid[d] = ov; s_ready[d] = ordy_o; s_busy[d] = ob; s_tag[d] = oe.tag;
      er_d[d] = er;
    end
    model_step(0, er_d[0]);
    model_step(1, er_d[1]);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset with a valid input pending
    in_valid = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_in_ready", 64'(a_in_ready), 64'd0);
    chk("rst_a_busy", 64'(a_busy), 64'd0);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    chk("rst_b_in_ready", 64'(b_in_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("post_rst_ready", 64'(s_ready[0]), 64'd1);

    // Basic latency: group 1 (L=3) tag 5 accepted at c0
    cyc(1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    chk("basic_accept", 64'(s_ready[0]), 64'd1);
    for (int c = 1; c <= 4; c++) begin
      cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      chk($sformatf("basic_c%0d_valid", c), 64'(s_valid[0]), (c == 3) ? 64'd1 : 64'd0);
      chk($sformatf("basic_c%0d_busy", c), 64'(s_busy[0]), (c <= 3) ? 64'd1 : 64'd0);
      if (c == 3) chk("basic_c3_tag", 64'(s_tag[0]), 64'd5);
    end
    idle(3);

    // Ordering: long op then short op, short op must wait
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
    chk("order_c1_ready", 64'(s_ready[0]), 64'd0);
    cyc(1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
    chk("order_c2_ready", 64'(s_ready[0]), 64'd0);
    cyc(1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
    chk("order_c3_ready", 64'(s_ready[0]), 64'd1);
    chk("order_c3_tag", 64'(s_tag[0]), 64'd1);
    chk("order_b_bypass_valid", 64'(s_valid[1]), 64'd1);
    chk("order_b_bypass_tag", 64'(s_tag[1]), 64'd2);
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("order_c4_valid", 64'(s_valid[0]), 64'd1);
    chk("order_c4_tag", 64'(s_tag[0]), 64'd2);
    idle(3);

    // Throughput: one group-0 result per cycle
    for (int i = 0; i <= 8; i++) begin
      cyc(i < 8, 1'b0, 5'(i), 1'b1, 1'b0);
      if (i < 8) chk($sformatf("tput_ready_%0d", i), 64'(s_ready[0]), 64'd1);
      if (i >= 1) begin
        chk($sformatf("tput_valid_%0d", i), 64'(s_valid[0]), 64'd1);
        chk($sformatf("tput_tag_%0d", i), 64'(s_tag[0]), 64'(i - 1));
      end
    end
    idle(3);

    // Backpressure while tag 5 is on the output
    cyc(1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
    for (int c = 3; c <= 5; c++) begin
      cyc(1'b1, 1'b0, 5'd6, 1'b0, 1'b0);
      chk($sformatf("bp_c%0d_valid", c), 64'(s_valid[0]), 64'd1);
      chk($sformatf("bp_c%0d_tag", c), 64'(s_tag[0]), 64'd5);
      chk($sformatf("bp_c%0d_ready", c), 64'(s_ready[0]), 64'd0);
    end
    cyc(1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    chk("bp_c6_tag", 64'(s_tag[0]), 64'd5);
    chk("bp_c6_ready", 64'(s_ready[0]), 64'd1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("bp_c7_valid", 64'(s_valid[0]), 64'd1);
    chk("bp_c7_tag", 64'(s_tag[0]), 64'd6);
    idle(3);

    // Flush with two entries in flight
    cyc(1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    chk("flush_c1_ready", 64'(s_ready[0]), 64'd1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    chk("flush_c2_valid_a", 64'(s_valid[0]), 64'd0);
    chk("flush_c2_valid_b", 64'(s_valid[1]), 64'd0);
    chk("flush_c2_ready", 64'(s_ready[0]), 64'd0);
    chk("flush_c2_busy", 64'(s_busy[0]), 64'd1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("flush_c3_busy", 64'(s_busy[0]), 64'd0);
    chk("flush_c3_valid", 64'(s_valid[0]), 64'd0);

    // Latency-0 bypass on an empty pipe, then blocked behind an in-flight op
    cyc(1'b1, 1'b0, 5'd20, 1'b1, 1'b0);
    chk("byp_valid", 64'(s_valid[1]), 64'd1);
    chk("byp_tag", 64'(s_tag[1]), 64'd20);
    chk("byp_busy", 64'(s_busy[1]), 64'd0);
    idle(2);
    cyc(1'b1, 1'b1, 5'd21, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 5'd22, 1'b1, 1'b0);
    chk("byp_blk_c1_ready", 64'(s_ready[1]), 64'd0);
    cyc(1'b1, 1'b0, 5'd22, 1'b1, 1'b0);
    chk("byp_blk_c2_ready", 64'(s_ready[1]), 64'd0);
    chk("byp_blk_c2_tag", 64'(s_tag[1]), 64'd21);
    cyc(1'b1, 1'b0, 5'd22, 1'b1, 1'b0);
    chk("byp_blk_c3_ready", 64'(s_ready[1]), 64'd1);
    chk("byp_blk_c3_tag", 64'(s_tag[1]), 64'd22);
    idle(3);

    // Asynchronous reset mid-flight
    cyc(1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    chk("arst_busy_before", 64'(a_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(a_busy), 64'd0);
    chk("arst_valid", 64'(a_out_valid), 64'd0);
    chk("arst_ready", 64'(a_in_ready), 64'd0);
    mq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
          $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
